seq_divider: RTL and testbench

- Sequential restoring divider: unsigned WIDTH-bit dividend / divisor -> quotient + remainder.
- Built around one shared subtract/compare step (ripple full adders, B inverted, carry-in 1), one quotient bit per clock.
- Sits beside the combinational add/sub/compare ALU as the multi-cycle arithmetic unit.
- Start/busy/done handshake toward the issuing controller.

---
 rtl/seq_divider_pkg.sv | 20 ++
 rtl/seq_divider_if.sv | 30 +++
 rtl/seq_divider_div_step.sv | 55 +++++
 rtl/seq_divider.sv | 139 +++++++++++++
 tb/tb_seq_divider.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared state encoding and sizing constants for the sequential divider.
// Signed operation is built in when SEQ_DIVIDER_SIGNED_EN is defined.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 4;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIX,
    DONE
  } div_state_t;

  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done request bus between an issuing controller and the divider.
// Shared by both builds (SEQ_DIVIDER_SIGNED_EN only changes the divider).
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient,
    input  remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient,
    output remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a quotient bit, trial-subtract.
// Identical in both builds (SEQ_DIVIDER_SIGNED_EN does not touch it).
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit,
  output logic             borrow
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   b;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] carry;
  logic             unused_cout;

  assign shifted  = {rem, q_msb};
  assign b        = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    fulladder u_fa (
      .a    (shifted[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign unused_cout = carry[WIDTH+1];
  assign borrow      = diff[WIDTH];
  assign q_bit       = ~borrow;

  // kept value is always below divisor, so its top bit is zero
  assign r_next = borrow ? shifted[WIDTH-1:0]
                         : diff[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam div_state_t RUN_EXIT = FIX;
`else
  localparam div_state_t RUN_EXIT = DONE;
`endif

  div_state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q, r, dvd, dvs;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] quo, rem;
  logic             dbz;
  logic             q_bit;
  logic             unused_borrow;
  logic             last;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q, neg_r;
`endif

  assign last = (cnt == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (r),
    .q_msb   (q[WIDTH-1]),
    .divisor (dvs),
    .r_next  (r_nx),
    .q_bit   (q_bit),
    .borrow  (unused_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // zero divisor settles through FIX so done lands two edges after accept
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = LOAD;
      LOAD: state_nx = (dvs == '0) ? FIX : RUN;
      RUN:  if (last) state_nx = RUN_EXIT;
      FIX:  state_nx = DONE;
      DONE: state_nx = bus.start ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= '0;
      r   <= '0;
      dvd <= '0;
      dvs <= '0;
      quo <= '0;
      rem <= '0;
      dbz <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dvd <= bus.dividend;
            dvs <= bus.divisor;
            q   <= bus.dividend;
            r   <= '0;
            cnt <= CNT_TOP;
          end
        end
        LOAD: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          neg_q <= dvd[WIDTH-1] ^ dvs[WIDTH-1];
          neg_r <= dvd[WIDTH-1];
          if (dvd[WIDTH-1]) q   <= -dvd;
          if (dvs[WIDTH-1]) dvs <= -dvs;
`endif
        end
        RUN: begin
          q   <= {q[WIDTH-2:0], q_bit};
          r   <= r_nx;
          cnt <= cnt - CNT_ONE;
`ifndef SEQ_DIVIDER_SIGNED_EN
          if (last) begin
            quo <= {q[WIDTH-2:0], q_bit};
            rem <= r_nx;
            dbz <= 1'b0;
          end
`endif
        end
        FIX: begin
          if (dvs == '0) begin
            quo <= '1;
            rem <= dvd;
            dbz <= 1'b1;
          end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            quo <= neg_q ? -q : q;
            rem <= neg_r ? -r : r;
`else
            quo <= q;
            rem <= r;
`endif
            dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == LOAD) ||
                           (state == RUN)  ||
                           (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH=4).
// Vectors switch with SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

  localparam int W = 4;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = W + 3;
  localparam logic [W-1:0] MA = 4'd7;
  localparam logic [W-1:0] MB = 4'd2;
  localparam logic [W-1:0] MQ = 4'd3;
  localparam logic [W-1:0] MR = 4'd1;
  localparam logic [W-1:0] RQ = 4'hc;
`else
  localparam int LAT = W + 2;
  localparam logic [W-1:0] MA = 4'd14;
  localparam logic [W-1:0] MB = 4'd4;
  localparam logic [W-1:0] MQ = 4'd3;
  localparam logic [W-1:0] MR = 4'd2;
  localparam logic [W-1:0] RQ = 4'd4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input string tag,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input int lat,
    input logic [W-1:0] eq,
    input logic [W-1:0] er,
    input logic ez
  );
    int n;
    int nb;
    nb = 0;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 40) begin
      if (bus.busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".busy"}, nb, lat - 1);
    chk({tag, ".bsy0"}, bus.busy, 1'b0);
    chk({tag, ".q"}, bus.quotient, eq);
    chk({tag, ".r"}, bus.remainder, er);
    chk({tag, ".dbz"}, bus.div_by_zero, ez);
  endtask

  initial begin
    int nd;
    logic [W-1:0] gq, gr;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.done", bus.done, 1'b0);
    chk("rst.q", bus.quotient, '0);
    chk("rst.r", bus.remainder, '0);
    chk("rst.dbz", bus.div_by_zero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op("m7/2", 4'h9, 4'h2, LAT, 4'hd, 4'hf, 1'b0);
    @(negedge clk);
    chk("m7/2.pulse", bus.done, 1'b0);
    run_op("m8/m1", 4'h8, 4'hf, LAT, 4'h8, 4'h0, 1'b0);
    run_op("7/m2", 4'h7, 4'he, LAT, 4'hd, 4'h1, 1'b0);
    @(negedge clk);
`else
    run_op("13/3", 4'd13, 4'd3, LAT, 4'd4, 4'd1, 1'b0);
    @(negedge clk);
    chk("13/3.pulse", bus.done, 1'b0);
    repeat (2) @(negedge clk);
    chk("13/3.hold", bus.quotient, 4'd4);
    run_op("3/7", 4'd3, 4'd7, LAT, 4'd0, 4'd3, 1'b0);
    run_op("15/1", 4'd15, 4'd1, LAT, 4'hf, 4'd0, 1'b0);
    @(negedge clk);
`endif
    run_op("5/0", 4'd5, 4'd0, 3, 4'hf, 4'd5, 1'b1);
    @(negedge clk);
    chk("5/0.hold", bus.div_by_zero, 1'b1);
    run_op("6/2", 4'd6, 4'd2, LAT, 4'd3, 4'd0, 1'b0);
    @(negedge clk);

    bus.start = 1'b1;
    bus.dividend = MA;
    bus.divisor = MB;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    gq = '0;
    gr = '0;
    repeat (12) begin
      if (bus.done) begin
        nd++;
        gq = bus.quotient;
        gr = bus.remainder;
      end
      @(negedge clk);
    end
    chk("ign.ndone", nd, 1);
    chk("ign.q", gq, MQ);
    chk("ign.r", gr, MR);

    bus.start = 1'b1;
    bus.dividend = 4'd11;
    bus.divisor = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.q", bus.quotient, '0);
    chk("arst.r", bus.remainder, '0);
    chk("arst.busy", bus.busy, 1'b0);
    chk("arst.done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      if (bus.done) nd++;
      @(negedge clk);
    end
    chk("arst.nodone", nd, 0);
    run_op("8/2", 4'd8, 4'd2, LAT, RQ, 4'd0, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
